// File: rtl/sme_pkg.sv
// Shared types and defaults for the SME RNG sequencing blocks.
package sme_pkg;

  typedef enum logic [1:0] {RC_WARMUP, RC_SERVE, RC_RESEED} sme_rng_st_t;

  localparam int SME_RESEED_INT_DEF = 1024;
  localparam int SME_WARMUP_DEF     = 16;

  function automatic int sme_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sme_rr_arb.sv
// Round-robin arbiter: grants the lowest requesting index above the last
// winner (wrapping); the pointer moves only when a grant is issued.
module sme_rr_arb #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] win;
  logic          found;

  // Two passes: indices strictly above the pointer first, then the wrap-around.
  always_comb begin
    grant = '0;
    win   = ptr_q;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i > int'(ptr_q))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        win      = PW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i <= int'(ptr_q))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        win      = PW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= PW'(N - 1);
    end else if (found) begin
      ptr_q <= win;
    end
  end

endmodule

// File: rtl/sme_rng_ctrl.sv
// Shares the SME RNG bank between NREQ consumers, reseeds it serially and re-diffuses it.
// Build option: SME_RNG_IDLE_STEP_EN makes the bank free-run in SERVE.
//
//  state     | meaning
//  RC_WARMUP | WARMUP bank updates, no grants
//  RC_SERVE  | round-robin grants; a seed offer moves to RESEED
//  RC_RESEED | XLEN cycles shifting the seed into the bank tap, LSB first
module sme_rng_ctrl
  import sme_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int XLEN       = 32,
  parameter int WARMUP     = SME_WARMUP_DEF,
  parameter int RESEED_INT = SME_RESEED_INT_DEF
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_grant,
  input  logic            seed_valid,
  input  logic [XLEN-1:0] seed_data,
  output logic            seed_ready,
  output logic            rng_update,
  output logic            rng_tap,
  output logic            rng_ready,
  output logic            reseed_due
);

  localparam int CW = $clog2(sme_max(WARMUP, XLEN) + 1);
  localparam int GW = $clog2(RESEED_INT + 1);

  localparam logic [CW-1:0] WARM_LAST = CW'(WARMUP - 1);
  localparam logic [CW-1:0] XLEN_LAST = CW'(XLEN - 1);
  localparam logic [GW-1:0] GCNT_MAX  = GW'(RESEED_INT);

  sme_rng_st_t     state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   gcnt_q;
  logic [XLEN-1:0] seed_q;
  logic            serve_en;
  logic            seed_take;
  logic [NREQ-1:0] arb_req;
  logic [NREQ-1:0] arb_grant;

  assign arb_req = req_valid & {NREQ{serve_en}};

  sme_rr_arb #(.N(NREQ)) u_arb (
    .clk   (g_clk),
    .reset (g_reset),
    .req   (arb_req),
    .grant (arb_grant)
  );

  assign req_grant  = arb_grant;
  assign reseed_due = !g_reset && (gcnt_q == GCNT_MAX);

  // Outputs are forced low while reset is held so the bank is never stepped under reset.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    seed_ready = 1'b0;
    seed_take  = 1'b0;
    rng_update = 1'b0;
    rng_tap    = 1'b0;
    rng_ready  = 1'b0;
    serve_en   = 1'b0;
    if (!g_reset) begin
      case (state_q)
        RC_WARMUP: begin
          rng_update = 1'b1;
          if (cnt_q == WARM_LAST) begin
            state_d = RC_SERVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RC_SERVE: begin
          rng_ready = 1'b1;
          if (seed_valid) begin
            seed_ready = 1'b1;
            seed_take  = 1'b1;
            state_d    = RC_RESEED;
            cnt_d      = '0;
          end else begin
            serve_en = 1'b1;
          end
`ifdef SME_RNG_IDLE_STEP_EN
          rng_update = 1'b1;
`else
          rng_update = |arb_grant;
`endif
        end
        RC_RESEED: begin
          rng_update = 1'b1;
          rng_tap    = seed_q[0];
          if (cnt_q == XLEN_LAST) begin
            state_d = RC_WARMUP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = RC_WARMUP;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q <= RC_WARMUP;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      seed_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (seed_take) begin
        seed_q <= seed_data;
        gcnt_q <= '0;
      end else begin
        if (state_q == RC_RESEED) begin
          seed_q <= seed_q >> 1;
        end
        if ((|arb_grant) && (gcnt_q != GCNT_MAX)) begin
          gcnt_q <= gcnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sme_rng_ctrl.sv
// Scoreboard bench for sme_rng_ctrl: a cycle-level behavioural model pushes expected outputs,
// a negedge monitor pops and compares.
module tb_sme_rng_ctrl;

  localparam int NREQ = 3;
  localparam int XLEN = 32;
  localparam int WARM = 16;
  localparam int RINT = 4;

`ifdef SME_RNG_IDLE_STEP_EN
  localparam bit IDLE_STEP = 1'b1;
`else
  localparam bit IDLE_STEP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic            sv  = 1'b0;
  logic [XLEN-1:0] sd  = '0;
  logic [NREQ-1:0] grant;
  logic            seed_ready, rng_update, rng_tap, rng_ready, reseed_due;

  sme_rng_ctrl #(.NREQ(NREQ), .XLEN(XLEN), .WARMUP(WARM), .RESEED_INT(RINT)) dut (
    .g_clk      (clk),
    .g_reset    (rst),
    .req_valid  (req),
    .req_grant  (grant),
    .seed_valid (sv),
    .seed_data  (sd),
    .seed_ready (seed_ready),
    .rng_update (rng_update),
    .rng_tap    (rng_tap),
    .rng_ready  (rng_ready),
    .reseed_due (reseed_due)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NREQ-1:0] grant;
    logic            seed_ready;
    logic            update;
    logic            tap;
    logic            ready;
    logic            due;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Model state: mode 0 = warming up, 1 = serving, 2 = shifting seed bits.
  int   m_mode  = 0;
  int   m_left  = WARM;
  int   m_ptr   = NREQ - 1;
  int   m_count = 0;
  bit   m_bits[$];

  task automatic model_cycle();
    exp_t e;
    e = '0;
    if (rst) begin
      m_mode  = 0;
      m_left  = WARM;
      m_ptr   = NREQ - 1;
      m_count = 0;
      m_bits.delete();
    end else begin
      e.due = (m_count == RINT);
      case (m_mode)
        0: begin
          e.update = 1'b1;
          m_left--;
          if (m_left == 0) m_mode = 1;
        end
        1: begin
          e.ready = 1'b1;
          if (sv) begin
            e.seed_ready = 1'b1;
            e.update     = IDLE_STEP;
            m_bits.delete();
            for (int b = 0; b < XLEN; b++) m_bits.push_back(sd[b]);
            m_count = 0;
            m_mode  = 2;
          end else begin
            int  win;
            win = -1;
            for (int k = 1; k <= NREQ; k++) begin
              int i;
              i = (m_ptr + k) % NREQ;
              if (win < 0 && req[i]) win = i;
            end
            if (win >= 0) begin
              e.grant[win] = 1'b1;
              e.update     = 1'b1;
              m_ptr        = win;
              if (m_count < RINT) m_count++;
            end else begin
              e.update = IDLE_STEP;
            end
          end
        end
        default: begin
          e.update = 1'b1;
          e.tap    = m_bits.pop_front();
          if (m_bits.size() == 0) begin
            m_mode = 0;
            m_left = WARM;
          end
        end
      endcase
    end
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic [NREQ-1:0] rq, input logic s, input logic [XLEN-1:0] d);
    @(posedge clk);
    #1;
    rst = r;
    req = rq;
    sv  = s;
    sd  = d;
    model_cycle();
  endtask

  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      tests++;
      if (grant !== e.grant) begin
        fails++;
        $display("FAIL grant cyc=%0d got=%b exp=%b", cyc, grant, e.grant);
      end
      tests++;
      if ({seed_ready, rng_update, rng_tap, rng_ready, reseed_due} !==
          {e.seed_ready, e.update, e.tap, e.ready, e.due}) begin
        fails++;
        $display("FAIL ctrl cyc=%0d got sr/upd/tap/rdy/due=%b%b%b%b%b exp=%b%b%b%b%b", cyc,
                 seed_ready, rng_update, rng_tap, rng_ready, reseed_due,
                 e.seed_ready, e.update, e.tap, e.ready, e.due);
      end
    end
  end

  initial begin
    // reset, warmup, rotation over all requesters, reseed_due saturation
    repeat (2) step(1'b1, 3'b111, 1'b0, '0);
    repeat (WARM + 8) step(1'b0, 3'b111, 1'b0, '0);
    // sparse pattern alternates 0 and 2
    repeat (8) step(1'b0, 3'b101, 1'b0, '0);
    // reseed wins over requests, then warmup and resumed grants
    step(1'b0, 3'b111, 1'b1, 32'hA5A5_0001);
    repeat (XLEN + WARM + 6) step(1'b0, 3'b111, 1'b0, '0);
    // reset in the middle of a reseed at bit 10
    repeat (3) step(1'b0, 3'b011, 1'b0, '0);
    step(1'b0, 3'b111, 1'b1, 32'hFFFF_FFFF);
    repeat (10) step(1'b0, 3'b111, 1'b0, '0);
    step(1'b1, 3'b111, 1'b0, '0);
    repeat (WARM + 2) step(1'b0, 3'b111, 1'b0, '0);
    // idle SERVE behaviour
    repeat (6) step(1'b0, 3'b000, 1'b0, '0);
    // randomized traffic, seeds and occasional resets
    for (int n = 0; n < 2500; n++) begin
      logic r, s;
      r = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 39) == 0);
      step(r, NREQ'($urandom_range(0, 7)), s, $urandom);
    end
    step(1'b0, 3'b000, 1'b0, '0);
    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
